// File: rtl/seq_restoring_divider_if.sv
// Request/result bundle between the EX stage and the sequential divider.
// Master drives i_start/i_signed/operands/i_flush; slave returns busy/valid/results.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic             i_signed;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             i_flush;
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;

    modport master (
        output i_start, i_signed, i_dividend, i_divisor, i_flush,
        input  o_busy, o_valid, o_quotient, o_remainder
    );

    modport slave (
        input  i_start, i_signed, i_dividend, i_divisor, i_flush,
        output o_busy, o_valid, o_quotient, o_remainder
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one bit per cycle.
// Ports: i_clk, i_rst_n (async, active-low), bus (slave side of the request bundle).
module seq_restoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             valid_q, valid_d;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             no_borrow;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        dvd_neg = bus.i_signed & bus.i_dividend[WIDTH-1];
        dvs_neg = bus.i_signed & bus.i_divisor[WIDTH-1];

        // Full WIDTH+1 bit shifted remainder: the remainder MSB may be set
        // when the divisor is large, so it must not be dropped.
        shifted   = {rem_q, dvd_q[WIDTH-1]};
        diff      = {1'b0, shifted} - {2'b00, dvs_q};
        no_borrow = ~diff[WIDTH+1];

        // Quotient bits shift into dvd from the LSB, so dvd holds the
        // quotient magnitude once the counter has run out.
        quo_fix = neg_quo_q ? ({WIDTH{1'b0}} - dvd_q) : dvd_q;
        rem_fix = neg_rem_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        valid_d   = 1'b0;

        if (bus.i_flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.i_start) begin
                        state_d   = S_CALC;
                        cnt_d     = CW'(WIDTH);
                        dvd_d     = dvd_neg ? ({WIDTH{1'b0}} - bus.i_dividend)
                                            : bus.i_dividend;
                        dvs_d     = dvs_neg ? ({WIDTH{1'b0}} - bus.i_divisor)
                                            : bus.i_divisor;
                        rem_d     = '0;
                        neg_quo_d = dvd_neg ^ dvs_neg;
                        neg_rem_d = dvd_neg;
                        dz_d      = (bus.i_divisor == '0);
                        ovf_d     = bus.i_signed
                                  & (bus.i_dividend == MIN_NEG)
                                  & (bus.i_divisor == '1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    if (cnt_q != '0) begin
                        rem_d = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                        dvd_d = {dvd_q[WIDTH-2:0], no_borrow};
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        // Fix-up cycle: sign correction and special cases.
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        if (dz_q) begin
                            // Divisor 0 never borrows, so rem ends as |dividend|;
                            // re-applying the dividend sign restores the original.
                            quo_out_d = '1;
                            rem_out_d = rem_fix;
                        end else if (ovf_q) begin
                            quo_out_d = MIN_NEG;
                            rem_out_d = '0;
                        end else begin
                            quo_out_d = quo_fix;
                            rem_out_d = rem_fix;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            valid_q   <= valid_d;
        end
    end

    // Busy covers the WIDTH iteration cycles; the final fix-up cycle is not
    // counted so the stall window is exactly WIDTH cycles.
    assign bus.o_busy      = (state_q == S_CALC) && (cnt_q != '0);
    assign bus.o_valid     = valid_q;
    assign bus.o_quotient  = quo_out_q;
    assign bus.o_remainder = rem_out_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (WIDTH=32).
// Drives at negedge, samples at negedge; expected results queued at start.
module tb_seq_restoring_divider;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } res_t;

    res_t exp_q[$];

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic res_t ref_div(input logic sgn, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        res_t res;
        if (b == '0) begin
            res.q = '1;
            res.r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res.q = a;
            res.r = '0;
        end else if (sgn) begin
            res.q = $signed(a) / $signed(b);
            res.r = $signed(a) % $signed(b);
        end else begin
            res.q = a / b;
            res.r = a % b;
        end
        return res;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.o_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'(bus.o_valid), 64'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("quotient", 64'(bus.o_quotient), 64'(e.q));
                check("remainder", 64'(bus.o_remainder), 64'(e.r));
            end
        end
    end

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic sgn, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit push);
        if (push) exp_q.push_back(ref_div(sgn, a, b));
        bus.i_start    = 1'b1;
        bus.i_signed   = sgn;
        bus.i_dividend = a;
        bus.i_divisor  = b;
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_result(input int lat0, output int lat, output int busy_n);
        lat    = lat0;
        busy_n = 0;
        while (!bus.o_valid && lat < 100) begin
            busy_n += int'(bus.o_busy);
            @(negedge clk);
            lat++;
        end
        if (!bus.o_valid) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int lat, busy_n;
        start_op(sgn, a, b, 1'b1);
        wait_result(0, lat, busy_n);
        check("latency", 64'(lat), 64'd33);
        check("busy_cycles", 64'(busy_n), 64'd32);
        @(negedge clk);
        check("valid_pulse", 64'(bus.o_valid), 64'd0);
    endtask

    initial begin
        int lat, busy_n;
        logic [W-1:0] sq, sr, a, b;
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        bus.i_start    = 1'b0;
        bus.i_signed   = 1'b0;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
        bus.i_flush    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.o_busy), 64'd0);
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_q", 64'(bus.o_quotient), 64'd0);
        check("rst_r", 64'(bus.o_remainder), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 32'd100, 32'd7);
        run_op(1'b1, -32'sd7, 32'd2);
        run_op(1'b1, 32'd7, -32'sd2);
        run_op(1'b0, 32'd5, 32'd0);
        run_op(1'b1, -32'sd5, 32'd0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 300)) : $urandom;
            run_op(1'(i % 2), a, b);
        end

        // Start while busy is ignored.
        start_op(1'b0, 32'd100, 32'd7, 1'b1);
        repeat (10) @(negedge clk);
        bus.i_start    = 1'b1;
        bus.i_signed   = 1'b1;
        bus.i_dividend = 32'd9;
        bus.i_divisor  = 32'd3;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_result(11, lat, busy_n);
        check("busy_ignore_lat", 64'(lat), 64'd33);
        @(negedge clk);

        // Back-to-back: new start in the DONE cycle.
        start_op(1'b0, 32'd1000, 32'd3, 1'b1);
        wait_result(0, lat, busy_n);
        start_op(1'b1, -32'sd1000, 32'd7, 1'b1);
        wait_result(0, lat, busy_n);
        check("b2b_latency", 64'(lat), 64'd33);
        @(negedge clk);

        // Flush mid-operation.
        sq = bus.o_quotient;
        sr = bus.o_remainder;
        start_op(1'b0, 32'd50, 32'd4, 1'b0);
        repeat (4) @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        check("flush_busy", 64'(bus.o_busy), 64'd0);
        repeat (40) @(negedge clk);
        check("flush_q_hold", 64'(bus.o_quotient), 64'(sq));
        check("flush_r_hold", 64'(bus.o_remainder), 64'(sr));

        // Flush beats start on the same edge.
        bus.i_flush = 1'b1;
        start_op(1'b0, 32'd50, 32'd4, 1'b0);
        bus.i_flush = 1'b0;
        check("flush_vs_start", 64'(bus.o_busy), 64'd0);
        repeat (40) @(negedge clk);

        // Reset mid-calculation.
        start_op(1'b0, 32'd77, 32'd5, 1'b0);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_q", 64'(bus.o_quotient), 64'd0);
        check("midrst_r", 64'(bus.o_remainder), 64'd0);
        check("midrst_busy", 64'(bus.o_busy), 64'd0);
        check("midrst_valid", 64'(bus.o_valid), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_idle_q", 64'(bus.o_quotient), 64'd0);
        run_op(1'b0, 32'd9, 32'd3);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
